// File: rtl/stream_upsizer_if.sv
// Purpose: handshake bundle for the narrow-to-wide stream converter (narrow in_* side, wide out_* side).
// Latency: none, wires only.
// Backpressure: in_ready/out_ready travel opposite to the data on each side.
interface stream_upsizer_if #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
);
  logic [IN_WIDTH-1:0]       in_data;
  logic                      in_last;
  logic                      in_valid;
  logic                      in_ready;
  logic [IN_WIDTH*RATIO-1:0] out_data;
  logic [RATIO-1:0]          out_keep;
  logic                      out_last;
  logic                      out_valid;
  logic                      out_ready;

  // Converter side: consumes narrow beats, produces wide words.
  modport slave (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, out_data, out_keep, out_last, out_valid
  );

  // Environment side: produces narrow beats, consumes wide words.
  modport master (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_keep, out_last, out_valid
  );
endinterface

// File: rtl/stream_upsizer.sv
// Purpose: packs RATIO narrow beats into one wide word with per-lane keep; in_last closes a word early.
// Latency: word valid the cycle after its completing beat is accepted; one beat per cycle sustained.
// Backpressure: single output register; in_ready = !out_valid || out_ready, combinational from out_ready.
module stream_upsizer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input logic             clk,
  input logic             reset_n,
  stream_upsizer_if.slave bus
);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CNT_W     = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]     cnt;
  logic [OUT_WIDTH-1:0] acc_data;
  logic [RATIO-1:0]     acc_keep;

  logic [OUT_WIDTH-1:0] out_data_q;
  logic [RATIO-1:0]     out_keep_q;
  logic                 out_last_q;
  logic                 out_valid_q;

  logic                 in_ready;
  logic                 rx;
  logic                 tx;
  logic                 done;
  logic [OUT_WIDTH-1:0] nxt_data;
  logic [RATIO-1:0]     nxt_keep;

  // Held low through reset so nothing is taken while state is being cleared.
  assign in_ready = reset_n && (!out_valid_q || bus.out_ready);
  assign rx       = bus.in_valid && in_ready;
  assign tx       = out_valid_q && bus.out_ready;
  // A last beat landing in the top lane is one completion, not two.
  assign done     = rx && ((cnt == LAST_LANE) || bus.in_last);

  // Accumulator with the incoming beat merged into the current lane.
  always_comb begin
    nxt_data = acc_data;
    nxt_keep = acc_keep;
    nxt_data[cnt*IN_WIDTH +: IN_WIDTH] = bus.in_data;
    nxt_keep[cnt] = 1'b1;
  end

  // Lane counter and accumulator; cleared on completion so lanes above the last one stay zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      acc_data <= '0;
      acc_keep <= '0;
    end else if (done) begin
      cnt      <= '0;
      acc_data <= '0;
      acc_keep <= '0;
    end else if (rx) begin
      cnt      <= cnt + 1'b1;
      acc_data <= nxt_data;
      acc_keep <= nxt_keep;
    end
  end

  // Output word register; only loads when in_ready is high, so a stalled word never changes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (done) begin
      out_data_q  <= nxt_data;
      out_keep_q  <= nxt_keep;
      out_last_q  <= bus.in_last;
      out_valid_q <= 1'b1;
    end else if (tx) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_stream_upsizer.sv
// Purpose: scoreboard bench for stream_upsizer (IN_WIDTH=8, RATIO=4): directed words, streaming, stalls, reset.
// Latency: expected words queued at stimulus time, popped by a monitor on every output handshake.
// Backpressure: out_ready fixed or randomised by a dedicated process; stalled outputs checked for stability.
module tb_stream_upsizer;
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  logic clk;
  logic reset_n;
  int   compared;
  int   mismatched;

  word_t exp_q[$];

  // Reference packer used for the random phases.
  bit          use_model;
  int          m_cnt;
  logic [31:0] m_data;
  logic [3:0]  m_keep;

  bit rand_rdy;
  bit rdy_fixed;

  stream_upsizer_if #(.IN_WIDTH(8), .RATIO(4)) bus ();

  stream_upsizer #(.IN_WIDTH(8), .RATIO(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_data = '0;
    m_keep = '0;
  endtask

  // Drives out_ready a little after each rising edge, after the stimulus block has settled.
  always @(posedge clk) begin
    #2;
    bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // Monitor: pops on each output handshake and checks the hold rule while stalled.
  logic        prev_stall;
  logic [37:0] prev_out;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {bus.out_data, bus.out_keep, bus.out_last, bus.out_valid}, prev_out);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {bus.out_data, bus.out_keep, bus.out_last}, 64'hdead);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          check("out_word", {bus.out_data, bus.out_keep, bus.out_last}, w);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.out_data, bus.out_keep, bus.out_last, bus.out_valid};
    end
  end

  // Presents one beat and returns just after the edge that accepted it; in_valid is left high.
  task automatic send_beat(input logic [7:0] d, input logic l, input bit strict);
    int waited;
    bit acc;
    waited = 0;
    acc    = 0;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      if (strict) check("in_ready_stream", bus.in_ready, 1'b1);
      if (bus.in_ready) acc = 1;
      waited++;
      @(posedge clk);
      #1;
      if (!acc && waited > 200) begin
        check("beat_timeout", 0, 1);
        break;
      end
    end
    if (acc && use_model) begin
      m_data[m_cnt*8 +: 8] = d;
      m_keep[m_cnt] = 1'b1;
      if (m_cnt == 3 || l) begin
        exp_q.push_back({m_data, m_keep, l});
        model_reset();
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    bus.in_valid = 1'b0;
    while (exp_q.size() != 0 && waited < 300) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    use_model  = 0;
    rand_rdy   = 0;
    rdy_fixed  = 1;
    model_reset();
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;

    // Reset state with a beat offered: nothing accepted, everything zero.
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_keep", bus.out_keep, 0);
    check("rst_out_last", bus.out_last, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    reset_n = 1'b1;
    idle(2);

    // Full word, and valid for exactly one cycle.
    exp_q.push_back({32'h44332211, 4'b1111, 1'b0});
    send_beat(8'h11, 0, 0);
    send_beat(8'h22, 0, 0);
    send_beat(8'h33, 0, 0);
    send_beat(8'h44, 0, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("full_valid", bus.out_valid, 1);
    check("full_data", bus.out_data, 32'h44332211);
    @(negedge clk);
    check("full_one_cycle", bus.out_valid, 0);
    @(posedge clk);
    #1;

    // Short packet, then the next word restarts in lane 0.
    exp_q.push_back({32'h0000BBAA, 4'b0011, 1'b1});
    send_beat(8'hAA, 0, 0);
    send_beat(8'hBB, 1, 0);
    exp_q.push_back({32'hFFEEDDCC, 4'b1111, 1'b0});
    send_beat(8'hCC, 0, 0);
    send_beat(8'hDD, 0, 0);
    send_beat(8'hEE, 0, 0);
    send_beat(8'hFF, 0, 0);
    idle(2);

    // Backpressure: a held word blocks further beats until out_ready returns.
    rdy_fixed = 0;
    idle(1);
    exp_q.push_back({32'h04030201, 4'b1111, 1'b0});
    send_beat(8'h01, 0, 0);
    send_beat(8'h02, 0, 0);
    send_beat(8'h03, 0, 0);
    send_beat(8'h04, 0, 0);
    bus.in_data  = 8'h55;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_data", bus.out_data, 32'h04030201);
      check("bp_out_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
    end
    rdy_fixed = 1;
    @(negedge clk);
    check("bp_release_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    exp_q.push_back({32'h88776655, 4'b1111, 1'b0});
    send_beat(8'h66, 0, 0);
    send_beat(8'h77, 0, 0);
    send_beat(8'h88, 0, 0);
    drain();

    // Back-to-back streaming with random packet boundaries.
    use_model = 1;
    model_reset();
    for (int i = 0; i < 64; i++)
      send_beat(8'($urandom_range(0, 255)), (i == 63) ? 1'b1 : ($urandom_range(0, 3) == 0), 1);
    drain();

    // Random source gaps and random sink stalls.
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      send_beat(8'($urandom_range(0, 255)), (i == 299) ? 1'b1 : ($urandom_range(0, 4) == 0), 0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    rand_rdy  = 0;
    rdy_fixed = 1;
    drain();

    // Reset mid-packet: partial word discarded, stale output register cleared without a clock.
    send_beat(8'h10, 0, 0);
    send_beat(8'h11, 0, 0);
    send_beat(8'h12, 0, 0);
    send_beat(8'h13, 0, 0);
    send_beat(8'h20, 0, 0);
    send_beat(8'h21, 0, 0);
    bus.in_valid = 1'b0;
    drain();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_data", bus.out_data, 0);
    check("mid_rst_out_keep", bus.out_keep, 0);
    check("mid_rst_out_last", bus.out_last, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    repeat (2) @(negedge clk);
    check("mid_rst_hold_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    exp_q.push_back({32'h33323130, 4'b1111, 1'b0});
    use_model = 0;
    send_beat(8'h30, 0, 0);
    send_beat(8'h31, 0, 0);
    send_beat(8'h32, 0, 0);
    send_beat(8'h33, 0, 0);
    drain();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
